framebuffer_scanout: RTL and testbench

- Display-side reader of the framebuffer memory. Drives its synchronous read port (20-bit address, 24-bit RGB, data one clock after address).
- Generates raster timing (hsync, vsync, data-enable) and emits one aligned 24-bit pixel per clock to the video output.
- Latches a frame base address once per frame, so the writer can double-buffer without tearing.

---
 rtl/framebuffer_scanout_if.sv | 37 +++
 rtl/framebuffer_scanout.sv | 139 +++++++++++++
 tb/tb_framebuffer_scanout.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/framebuffer_scanout_if.sv
// framebuffer_scanout_if
//   Bundles the scanout block's control, framebuffer read port and video
//   output into one interface.
//   master : the scanout engine (drives read address and video outputs)
//   slave  : the surrounding system (drives enable, base, read data)
//   Signals:
//     en          scanout enable
//     fb_base     frame base address, sampled at start of frame
//     fb_raddr    framebuffer read address (registered)
//     fb_rdata    framebuffer read data, valid one clock after fb_raddr
//     pix_rgb     pixel data, 0 when pix_de low
//     pix_de      active-video flag
//     hsync/vsync sync outputs
//     vblank      output line is at or beyond the active line count
//     frame_start one-clock pulse with the first output cycle of a frame
interface framebuffer_scanout_if;
   logic        en;
   logic [19:0] fb_base;
   logic [19:0] fb_raddr;
   logic [23:0] fb_rdata;
   logic [23:0] pix_rgb;
   logic        pix_de;
   logic        hsync;
   logic        vsync;
   logic        vblank;
   logic        frame_start;

   modport master (
      input  en, fb_base, fb_rdata,
      output fb_raddr, pix_rgb, pix_de, hsync, vsync, vblank, frame_start
   );

   modport slave (
      output en, fb_base, fb_rdata,
      input  fb_raddr, pix_rgb, pix_de, hsync, vsync, vblank, frame_start
   );
endinterface

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout
//   Display-side reader of the framebuffer. Generates raster timing, issues
//   one synchronous read per active pixel and emits pixel data aligned with
//   hsync/vsync/de. The frame base is latched once per frame so the writer
//   can double-buffer without tearing.
//   Ports:
//     clk    pixel clock
//     rst_n  asynchronous active-low reset
//     bus    framebuffer_scanout_if.master (en, fb_base, fb_raddr, fb_rdata,
//            pix_rgb, pix_de, hsync, vsync, vblank, frame_start)
//   All outputs for raster position (h,v) appear 3 clocks after the counters
//   hold (h,v).
module framebuffer_scanout #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned STRIDE      = 1024,
   parameter logic        SYNC_ACTIVE = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   framebuffer_scanout_if.master  bus
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
      logic vb;
      logic sof;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{act: 1'b0, hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE,
                                 vb: 1'b0, sof: 1'b0};

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [19:0]   line_base;
   logic [19:0]   rd_base;
   logic [19:0]   fb_raddr_q;
   logic [23:0]   pix_rgb_q;
   logic          h_last;
   logic          v_last;
   logic          frame_origin;
   ctl_t          ctl_raw;
   ctl_t          ctl_p1;
   ctl_t          ctl_p2;
   ctl_t          ctl_q;

   // Stage 0 decode
   always_comb begin
      h_last       = (32'(h_cnt) == H_TOTAL - 1);
      v_last       = (32'(v_cnt) == V_TOTAL - 1);
      frame_origin = (h_cnt == '0) && (v_cnt == '0);
      ctl_raw      = CTL_IDLE;
      if (bus.en) begin
         ctl_raw.act = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
         ctl_raw.hs  = ((32'(h_cnt) >= H_ACTIVE + H_FP) &&
                        (32'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         ctl_raw.vs  = ((32'(v_cnt) >= V_ACTIVE + V_FP) &&
                        (32'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         ctl_raw.vb  = (32'(v_cnt) >= V_ACTIVE);
         ctl_raw.sof = frame_origin;
      end
      // line_base only takes the new frame base on this same edge, so the
      // first read of a frame uses fb_base directly.
      rd_base = frame_origin ? bus.fb_base : line_base;
   end

   // Raster counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!bus.en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Per-line start address; reloaded from fb_base once per frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_base <= '0;
      end else if (!bus.en || frame_origin) begin
         line_base <= bus.fb_base;
      end else if (h_last && (32'(v_cnt) < V_ACTIVE - 1)) begin
         line_base <= line_base + 20'(STRIDE);
      end
   end

   // Read address (stage 1); holds outside active video
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_raddr_q <= '0;
      end else if (ctl_raw.act) begin
         fb_raddr_q <= rd_base + 20'(h_cnt);
      end
   end

   // Control delay line matched to address register + memory latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_p1    <= CTL_IDLE;
         ctl_p2    <= CTL_IDLE;
         ctl_q     <= CTL_IDLE;
         pix_rgb_q <= '0;
      end else begin
         ctl_p1    <= ctl_raw;
         ctl_p2    <= ctl_p1;
         ctl_q     <= ctl_p2;
         pix_rgb_q <= ctl_p2.act ? bus.fb_rdata : '0;
      end
   end

   assign bus.fb_raddr    = fb_raddr_q;
   assign bus.pix_rgb     = pix_rgb_q;
   assign bus.pix_de      = ctl_q.act;
   assign bus.hsync       = ctl_q.hs;
   assign bus.vsync       = ctl_q.vs;
   assign bus.vblank      = ctl_q.vb;
   assign bus.frame_start = ctl_q.sof;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout
//   Directed bench for framebuffer_scanout using a reduced raster
//   (16 clocks x 10 lines, 8x6 active) with STRIDE 1024. The memory model
//   returns data equal to the address read.
module tb_framebuffer_scanout;

   localparam logic [4:0] IDLE = 5'b01100;  // {de,hs,vs,vb,fs}

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [19:0] fbase [0:3];
   logic [19:0] exp_raddr;

   framebuffer_scanout_if fb_bus();

   framebuffer_scanout #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .STRIDE(1024), .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (fb_bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) fb_bus.fb_rdata <= {4'h0, fb_bus.fb_raddr};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic is_active(int p);
      int h = p % 16;
      int v = (p / 16) % 10;
      return (h < 8) && (v < 6);
   endfunction

   function automatic logic [19:0] addr_of(int p);
      int f = p / 160;
      int h = p % 16;
      int v = (p / 16) % 10;
      return fbase[f] + 20'(v * 1024) + 20'(h);
   endfunction

   function automatic logic [4:0] ctl_of(int p);
      int   h = p % 16;
      int   v = (p / 16) % 10;
      logic de = (h < 8) && (v < 6);
      logic hs = !((h >= 10) && (h < 13));
      logic vs = !((v >= 7) && (v < 9));
      logic vb = (v >= 6);
      logic fs = ((p % 160) == 0);
      return {de, hs, vs, vb, fs};
   endfunction

   function automatic logic [4:0] obs_ctl();
      return {fb_bus.pix_de, fb_bus.hsync, fb_bus.vsync, fb_bus.vblank, fb_bus.frame_start};
   endfunction

   // k = number of en-high edges since scanning (re)started
   task automatic step_check(input int k);
      logic [4:0]  ec;
      logic [23:0] er;
      if (is_active(k - 1)) exp_raddr = addr_of(k - 1);
      check_val($sformatf("raddr k%0d", k), 32'(fb_bus.fb_raddr), 32'(exp_raddr));
      if (k >= 3) begin
         ec = ctl_of(k - 3);
         er = ec[4] ? {4'h0, addr_of(k - 3)} : 24'h0;
      end else begin
         ec = IDLE;
         er = 24'h0;
      end
      check_val($sformatf("ctl k%0d", k), 32'(obs_ctl()), 32'(ec));
      check_val($sformatf("rgb k%0d", k), 32'(fb_bus.pix_rgb), 32'(er));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      fb_bus.en      = 1'b1;
      fb_bus.fb_base = 20'h0;
      fbase          = '{20'h00000, 20'h80000, 20'hFFE00, 20'hFFE00};
      exp_raddr      = 20'h0;

      // Reset held
      repeat (3) @(negedge clk);
      check_val("rst raddr", 32'(fb_bus.fb_raddr), 32'h0);
      check_val("rst ctl",   32'(obs_ctl()),       32'(IDLE));
      check_val("rst rgb",   32'(fb_bus.pix_rgb),  32'h0);
      rst_n = 1'b1;

      // Three full frames plus part of a fourth
      for (int k = 1; k <= 517; k++) begin
         tick();
         step_check(k);
         if (k == 3)   check_val("sof first",    32'(fb_bus.frame_start), 32'h1);
         if (k == 17)  check_val("line1 addr",   32'(fb_bus.fb_raddr), 32'h00400);
         if (k == 49)  check_val("base hold",    32'(fb_bus.fb_raddr), 32'h00C00);
         if (k == 161) check_val("new base",     32'(fb_bus.fb_raddr), 32'h80000);
         if (k == 337) check_val("wrap line1",   32'(fb_bus.fb_raddr), 32'h00200);
         if (k == 48)  fb_bus.fb_base = 20'h80000;
         if (k == 200) fb_bus.fb_base = 20'hFFE00;
      end

      // Drop en at line 2, h=5 of frame 3
      fb_bus.en = 1'b0;
      tick();
      check_val("drop1 ctl",   32'(obs_ctl()),       32'h1C);
      check_val("drop1 rgb",   32'(fb_bus.pix_rgb),  32'h00603);
      check_val("drop1 raddr", 32'(fb_bus.fb_raddr), 32'h00604);
      tick();
      check_val("drop2 ctl",   32'(obs_ctl()),       32'h1C);
      check_val("drop2 rgb",   32'(fb_bus.pix_rgb),  32'h00604);
      tick();
      check_val("drop3 ctl",   32'(obs_ctl()),       32'(IDLE));
      check_val("drop3 rgb",   32'(fb_bus.pix_rgb),  32'h0);
      fb_bus.fb_base = 20'h12345;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("off ctl %0d", i),   32'(obs_ctl()),       32'(IDLE));
         check_val($sformatf("off raddr %0d", i), 32'(fb_bus.fb_raddr), 32'h00604);
      end

      // Restart
      fb_bus.en = 1'b1;
      fbase[0]  = 20'h12345;
      for (int k = 1; k <= 40; k++) begin
         tick();
         step_check(k);
         if (k == 1) check_val("restart addr", 32'(fb_bus.fb_raddr), 32'h12345);
         if (k == 3) check_val("restart sof",  32'(fb_bus.frame_start), 32'h1);
      end

      // Asynchronous reset mid-frame
      #2 rst_n = 1'b0;
      #1;
      check_val("arst raddr", 32'(fb_bus.fb_raddr), 32'h0);
      check_val("arst ctl",   32'(obs_ctl()),       32'(IDLE));
      check_val("arst rgb",   32'(fb_bus.pix_rgb),  32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
